// File: rtl/cvita_chk_pkg.sv
// Shared types and constants for the CVITA ramp packet checker.
// Register offsets are relative to SR_BASE; header positions index the 64-bit CHDR header line.
package cvita_chk_pkg;

  typedef enum logic [1:0] {S_HDR, S_TIME, S_BODY} state_t;

  localparam int SR_START = 0;
  localparam int SR_STEP  = 1;
  localparam int SR_CTRL  = 2;
  localparam int SR_RBSEL = 3;

  localparam logic [1:0] RB_STATS = 2'd0;
  localparam logic [1:0] RB_ERRS  = 2'd1;
  localparam logic [1:0] RB_CHK   = 2'd2;
  localparam logic [1:0] RB_LAST  = 2'd3;

  localparam int HDR_HAS_TIME = 61;
  localparam int HDR_SEQ_LO   = 48;
  localparam int HDR_SEQ_W    = 12;
  localparam int HDR_LEN_LO   = 32;
  localparam int HDR_LEN_W    = 16;
  localparam int HDR_SID_LO   = 0;
  localparam int HDR_SID_W    = 32;

endpackage

// File: rtl/cvita_chk_regs.sv
// Settings-bus register file for the ramp checker: ramp config, control, clear pulse
// and the registered readback multiplexer.
module cvita_chk_regs
  import cvita_chk_pkg::*;
#(
  parameter int SR_BASE = 0,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_stb,
  input  logic [7:0]       set_addr,
  input  logic [31:0]      set_data,
  input  logic [CNT_W-1:0] pkt_cnt,
  input  logic [CNT_W-1:0] word_err,
  input  logic [CNT_W-1:0] len_err,
  input  logic [CNT_W-1:0] seq_err,
  input  logic [63:0]      last_chk,
  input  logic [31:0]      last_sid,
  input  logic [15:0]      last_lines,
  output logic [63:0]      ramp_start,
  output logic [63:0]      ramp_step,
  output logic             enable,
  output logic             clear,
  output logic [63:0]      rb_data
);

  localparam logic [7:0] A_START = 8'(SR_BASE + SR_START);
  localparam logic [7:0] A_STEP  = 8'(SR_BASE + SR_STEP);
  localparam logic [7:0] A_CTRL  = 8'(SR_BASE + SR_CTRL);
  localparam logic [7:0] A_RBSEL = 8'(SR_BASE + SR_RBSEL);

  logic [31:0] start_q;
  logic [31:0] step_q;
  logic [1:0]  rb_sel;

  assign ramp_start = {32'h0, start_q};
  assign ramp_step  = {32'h0, step_q};

  // The clear bit is never stored; it only produces a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 32'h0;
      step_q  <= 32'h100;
      enable  <= 1'b1;
      rb_sel  <= RB_STATS;
      clear   <= 1'b0;
    end else begin
      clear <= set_stb && (set_addr == A_CTRL) && set_data[0];
      if (set_stb) begin
        case (set_addr)
          A_START: start_q <= set_data;
          A_STEP:  step_q  <= set_data;
          A_CTRL:  enable  <= set_data[1];
          A_RBSEL: rb_sel  <= set_data[1:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_data <= 64'h0;
    end else begin
      case (rb_sel)
        RB_STATS: rb_data <= {32'(pkt_cnt), 32'(word_err)};
        RB_ERRS:  rb_data <= {32'(len_err), 32'(seq_err)};
        RB_CHK:   rb_data <= last_chk;
        default:  rb_data <= {last_sid, 16'h0, last_lines};
      endcase
    end
  end

endmodule

// File: rtl/cvita_ramp_pkt_checker.sv
// CVITA/CHDR stream sink that checks ramp payloads, header length and sequence
// continuity, and keeps per-packet stats plus saturating error counters.
module cvita_ramp_pkt_checker
  import cvita_chk_pkg::*;
#(
  parameter int SR_BASE = 0,
  parameter int CNT_W   = 32
) (
  input  logic        bus_clk,
  input  logic        bus_rst_n,
  input  logic [63:0] i_tdata,
  input  logic        i_tlast,
  input  logic        i_tvalid,
  output logic        i_tready,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  output logic [63:0] rb_data,
  output logic        pkt_done,
  output logic        err_any
);

  state_t state, state_next;

  logic [63:0] ramp_start, ramp_step, exp_word, step_act, checksum, last_chk, fin_chk, chk_upd;
  logic        enable, clear, beat, eop, has_time, word_err_pkt, seq_valid;
  logic [11:0] seqnum, last_seq, fin_seq;
  logic [15:0] len_bytes, line_cnt, last_lines, fin_len, fin_lines, lines_inc;
  logic [31:0] sid, last_sid, fin_sid;
  logic [19:0] byte_cnt;
  logic        fin_has_time, fin_werr, force_len_err, word_mis, len_bad, seq_bad;
  logic [CNT_W-1:0] pkt_cnt, word_err_cnt, len_err_cnt, seq_err_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign i_tready  = enable;
  assign beat      = i_tvalid & i_tready;
  assign eop       = beat & i_tlast & ~clear;
  assign word_mis  = (i_tdata != exp_word);
  assign chk_upd   = {checksum[62:0], checksum[63]} ^ i_tdata;
  assign lines_inc = (&line_cnt) ? line_cnt : line_cnt + 16'd1;

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n)  state <= S_HDR;
    else if (clear)  state <= S_HDR;
    else             state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (beat) begin
      case (state)
        S_HDR:   if (!i_tlast) state_next = i_tdata[HDR_HAS_TIME] ? S_TIME : S_BODY;
        S_TIME:  state_next = i_tlast ? S_HDR : S_BODY;
        S_BODY:  if (i_tlast) state_next = S_HDR;
        default: state_next = S_HDR;
      endcase
    end
  end

  // Packet summary as it stands once the current beat is included, used on tlast.
  always_comb begin
    fin_has_time  = has_time;
    fin_seq       = seqnum;
    fin_len       = len_bytes;
    fin_sid       = sid;
    fin_lines     = line_cnt;
    fin_chk       = checksum;
    fin_werr      = word_err_pkt;
    force_len_err = 1'b0;
    case (state)
      S_HDR: begin
        fin_has_time  = i_tdata[HDR_HAS_TIME];
        fin_seq       = i_tdata[HDR_SEQ_LO +: HDR_SEQ_W];
        fin_len       = i_tdata[HDR_LEN_LO +: HDR_LEN_W];
        fin_sid       = i_tdata[HDR_SID_LO +: HDR_SID_W];
        fin_lines     = 16'd0;
        fin_chk       = 64'd0;
        fin_werr      = 1'b0;
        force_len_err = 1'b1;
      end
      S_BODY: begin
        fin_lines = lines_inc;
        fin_chk   = chk_upd;
        fin_werr  = word_err_pkt | word_mis;
      end
      default: ;
    endcase
    byte_cnt = (20'd1 + 20'(fin_has_time) + 20'(fin_lines)) << 3;
    len_bad  = force_len_err | (byte_cnt != 20'(fin_len));
    seq_bad  = seq_valid & (fin_seq != last_seq + 12'd1);
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      has_time <= 1'b0; seqnum <= '0; len_bytes <= '0; sid <= '0;
      line_cnt <= '0; checksum <= '0; exp_word <= '0; step_act <= '0;
      word_err_pkt <= 1'b0; last_seq <= '0; seq_valid <= 1'b0;
      pkt_cnt <= '0; word_err_cnt <= '0; len_err_cnt <= '0; seq_err_cnt <= '0;
      last_lines <= '0; last_chk <= '0; last_sid <= '0;
      pkt_done <= 1'b0; err_any <= 1'b0;
    end else if (clear) begin
      line_cnt <= '0; checksum <= '0; word_err_pkt <= 1'b0; seq_valid <= 1'b0;
      pkt_cnt <= '0; word_err_cnt <= '0; len_err_cnt <= '0; seq_err_cnt <= '0;
      last_lines <= '0; last_chk <= '0; last_sid <= '0;
      pkt_done <= 1'b0; err_any <= 1'b0;
    end else begin
      pkt_done <= eop;
      if (beat) begin
        case (state)
          S_HDR: begin
            has_time     <= i_tdata[HDR_HAS_TIME];
            seqnum       <= i_tdata[HDR_SEQ_LO +: HDR_SEQ_W];
            len_bytes    <= i_tdata[HDR_LEN_LO +: HDR_LEN_W];
            sid          <= i_tdata[HDR_SID_LO +: HDR_SID_W];
            line_cnt     <= '0;
            checksum     <= '0;
            word_err_pkt <= 1'b0;
            exp_word     <= ramp_start;
            step_act     <= ramp_step;
          end
          S_BODY: begin
            if (word_mis) word_err_pkt <= 1'b1;
            exp_word <= exp_word + step_act;
            line_cnt <= lines_inc;
            checksum <= chk_upd;
          end
          default: ;
        endcase
      end
      if (eop) begin
        pkt_cnt <= sat_inc(pkt_cnt);
        if (len_bad)  len_err_cnt  <= sat_inc(len_err_cnt);
        if (fin_werr) word_err_cnt <= sat_inc(word_err_cnt);
        if (seq_bad)  seq_err_cnt  <= sat_inc(seq_err_cnt);
        if (len_bad | fin_werr | seq_bad) err_any <= 1'b1;
        last_seq   <= fin_seq;
        seq_valid  <= 1'b1;
        last_lines <= fin_lines;
        last_chk   <= fin_chk;
        last_sid   <= fin_sid;
      end
    end
  end

  cvita_chk_regs #(
    .SR_BASE(SR_BASE),
    .CNT_W  (CNT_W)
  ) u_regs (
    .clk       (bus_clk),
    .rst_n     (bus_rst_n),
    .set_stb   (set_stb),
    .set_addr  (set_addr),
    .set_data  (set_data),
    .pkt_cnt   (pkt_cnt),
    .word_err  (word_err_cnt),
    .len_err   (len_err_cnt),
    .seq_err   (seq_err_cnt),
    .last_chk  (last_chk),
    .last_sid  (last_sid),
    .last_lines(last_lines),
    .ramp_start(ramp_start),
    .ramp_step (ramp_step),
    .enable    (enable),
    .clear     (clear),
    .rb_data   (rb_data)
  );

endmodule
